// File: rtl/psum_gbf_responder.sv
// Partial-sum global buffer, responder side of the psum write/read/init interface.
// Half-row writes, full-row zeroing, a 1-cycle write-first read port, and a
// drain FSM that streams finished rows downstream over valid/ready.
// Optional feature macro: PSUM_GBF_ZERO_ON_DRAIN_EN (zero each row as it drains).
module psum_gbf_responder #(
    parameter int unsigned HALF_BITWIDTH          = 256,
    parameter int unsigned PSUM_GBF_DATA_BITWIDTH = 512,
    parameter int unsigned PSUM_GBF_ADDR_BITWIDTH = 5,
    parameter int unsigned PSUM_GBF_DEPTH         = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              psum_gbf_w_en,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr,
    input  logic                              psum_gbf_w_num,
    input  logic [HALF_BITWIDTH-1:0]          psum_gbf_w_data,
    input  logic                              psum_gbf_r_en,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr,
    output logic [PSUM_GBF_DATA_BITWIDTH-1:0] psum_gbf_r_data,
    output logic                              psum_gbf_r_valid,
    input  logic                              psum_gbf_w_en_for_init,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init,
    output logic                              collision,
    input  logic                              drain_start,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] drain_base,
    input  logic [PSUM_GBF_ADDR_BITWIDTH:0]   drain_len,
    input  logic                              drain_ready,
    output logic                              drain_valid,
    output logic [PSUM_GBF_DATA_BITWIDTH-1:0] drain_data,
    output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] drain_addr,
    output logic                              drain_busy,
    output logic                              drain_done
);

    localparam int unsigned AW = PSUM_GBF_ADDR_BITWIDTH;
    localparam int unsigned LW = PSUM_GBF_ADDR_BITWIDTH + 1;
    localparam int unsigned DW = PSUM_GBF_DATA_BITWIDTH;
    localparam int unsigned HW = HALF_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    logic [DW-1:0] mem [PSUM_GBF_DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          dv_d, done_d;
    logic [DW-1:0] dd_d;
    logic [AW-1:0] da_d;

    logic          hs;
    logic          zero_hs;
    logic          init_hit_w;
    logic          zero_hit_w;
    logic          w_keep;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_row;

    // Handshake and write-drop decisions; init (and clear-on-drain) beat a write
    always_comb begin
        hs         = (state_q == ST_PRESENT) && drain_ready;
        zero_hs    = 1'b0;
        zero_hit_w = 1'b0;
        init_hit_w = psum_gbf_w_en_for_init && psum_gbf_w_en &&
                     (psum_gbf_w_addr_for_init == psum_gbf_w_addr);
`ifdef PSUM_GBF_ZERO_ON_DRAIN_EN
        zero_hs    = hs && reset;
        zero_hit_w = zero_hs && psum_gbf_w_en && (drain_addr == psum_gbf_w_addr);
`endif
        w_keep     = psum_gbf_w_en && !init_hit_w && !zero_hit_w;
    end

    // Shared read port with write-first bypass; external reads win over drain fetch
    always_comb begin
        rd_addr = psum_gbf_r_en ? psum_gbf_r_addr : ptr_q;
        rd_row  = mem[rd_addr];
        if (w_keep && (psum_gbf_w_addr == rd_addr)) begin
            if (psum_gbf_w_num) rd_row[DW-1:HW] = psum_gbf_w_data;
            else                rd_row[HW-1:0]  = psum_gbf_w_data;
        end
        if (psum_gbf_w_en_for_init && (psum_gbf_w_addr_for_init == rd_addr)) rd_row = '0;
        if (zero_hs && (drain_addr == rd_addr)) rd_row = '0;
    end

    // Row storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_keep) begin
            if (psum_gbf_w_num) mem[psum_gbf_w_addr][DW-1:HW] <= psum_gbf_w_data;
            else                mem[psum_gbf_w_addr][HW-1:0]  <= psum_gbf_w_data;
        end
        if (psum_gbf_w_en_for_init) mem[psum_gbf_w_addr_for_init] <= '0;
        if (zero_hs) mem[drain_addr] <= '0;
    end

    // Accumulation read result and sticky collision flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            psum_gbf_r_data  <= '0;
            psum_gbf_r_valid <= 1'b0;
            collision        <= 1'b0;
        end else begin
            psum_gbf_r_valid <= psum_gbf_r_en;
            if (psum_gbf_r_en) psum_gbf_r_data <= rd_row;
            if (init_hit_w || zero_hit_w) collision <= 1'b1;
        end
    end

    // Drain FSM next-state and output values
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        dv_d    = drain_valid;
        dd_d    = drain_data;
        da_d    = drain_addr;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (drain_start) begin
                    ptr_d   = drain_base;
                    rem_d   = (drain_len == '0) ? LW'(PSUM_GBF_DEPTH) : drain_len;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!psum_gbf_r_en) begin
                    dd_d    = rd_row;
                    da_d    = ptr_q;
                    dv_d    = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (hs) begin
                    dv_d = 1'b0;
                    if (rem_q > LW'(1)) begin
                        rem_d   = rem_q - LW'(1);
                        ptr_d   = ptr_q + AW'(1);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drain FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            drain_valid <= 1'b0;
            drain_data  <= '0;
            drain_addr  <= '0;
            drain_busy  <= 1'b0;
            drain_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            drain_valid <= dv_d;
            drain_data  <= dd_d;
            drain_addr  <= da_d;
            drain_busy  <= (state_d != ST_IDLE);
            drain_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_psum_gbf_responder.sv
// Randomized self-checking bench for psum_gbf_responder against a row-array model.
// Honours PSUM_GBF_ZERO_ON_DRAIN_EN when defined for both bench and design.
module tb_psum_gbf_responder;

    logic         clk;
    logic         reset;
    logic         psum_gbf_w_en;
    logic [4:0]   psum_gbf_w_addr;
    logic         psum_gbf_w_num;
    logic [255:0] psum_gbf_w_data;
    logic         psum_gbf_r_en;
    logic [4:0]   psum_gbf_r_addr;
    logic [511:0] psum_gbf_r_data;
    logic         psum_gbf_r_valid;
    logic         psum_gbf_w_en_for_init;
    logic [4:0]   psum_gbf_w_addr_for_init;
    logic         collision;
    logic         drain_start;
    logic [4:0]   drain_base;
    logic [5:0]   drain_len;
    logic         drain_ready;
    logic         drain_valid;
    logic [511:0] drain_data;
    logic [4:0]   drain_addr;
    logic         drain_busy;
    logic         drain_done;

    psum_gbf_responder dut (
        .clk                      (clk),
        .reset                    (reset),
        .psum_gbf_w_en            (psum_gbf_w_en),
        .psum_gbf_w_addr          (psum_gbf_w_addr),
        .psum_gbf_w_num           (psum_gbf_w_num),
        .psum_gbf_w_data          (psum_gbf_w_data),
        .psum_gbf_r_en            (psum_gbf_r_en),
        .psum_gbf_r_addr          (psum_gbf_r_addr),
        .psum_gbf_r_data          (psum_gbf_r_data),
        .psum_gbf_r_valid         (psum_gbf_r_valid),
        .psum_gbf_w_en_for_init   (psum_gbf_w_en_for_init),
        .psum_gbf_w_addr_for_init (psum_gbf_w_addr_for_init),
        .collision                (collision),
        .drain_start              (drain_start),
        .drain_base               (drain_base),
        .drain_len                (drain_len),
        .drain_ready              (drain_ready),
        .drain_valid              (drain_valid),
        .drain_data               (drain_data),
        .drain_addr               (drain_addr),
        .drain_busy               (drain_busy),
        .drain_done               (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: row contents, sticky collision, last read, drain order queue
    logic [511:0] model [32];
    bit           exp_col;
    bit           exp_rv;
    logic [511:0] exp_rdata;
    int           dq [$];
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        psum_gbf_w_en          = 1'b0;
        psum_gbf_w_addr        = '0;
        psum_gbf_w_num         = 1'b0;
        psum_gbf_w_data        = '0;
        psum_gbf_r_en          = 1'b0;
        psum_gbf_r_addr        = '0;
        psum_gbf_w_en_for_init = 1'b0;
        psum_gbf_w_addr_for_init = '0;
        drain_start            = 1'b0;
        drain_base             = '0;
        drain_len              = '0;
        drain_ready            = 1'b0;
    endtask

    // Apply the current inputs for one clock edge, update the model, check outputs
    task automatic tick();
        bit hs, done_exp, wdrop, chk_stall, chk_fetch;
        int ha, n;
        hs = 0; done_exp = 0; wdrop = 0;
        if (drain_valid === 1'b1) begin
            if (dq.size() == 0) begin
                check("dvalid_unexpected", 512'(drain_valid), 512'(0));
            end else begin
                check("drain_addr", 512'(drain_addr), 512'(dq[0]));
                check("drain_data", drain_data, model[dq[0]]);
                hs = drain_ready && reset;
            end
        end
        chk_stall = (drain_valid === 1'b0) && psum_gbf_r_en;
        chk_fetch = reset && (drain_valid === 1'b0) && (drain_busy === 1'b1) && !psum_gbf_r_en;
        if (!reset) begin
            dq.delete();
            exp_col   = 0;
            exp_rv    = 0;
            exp_rdata = '0;
        end else begin
            if (drain_start && dq.size() == 0) begin
                n = (drain_len == 0) ? 32 : int'(drain_len);
                for (int i = 0; i < n; i++) dq.push_back((int'(drain_base) + i) % 32);
            end
            if (hs) begin
                ha = dq.pop_front();
                done_exp = (dq.size() == 0);
`ifdef PSUM_GBF_ZERO_ON_DRAIN_EN
                model[ha] = '0;
                if (psum_gbf_w_en && int'(psum_gbf_w_addr) == ha) begin
                    wdrop = 1; exp_col = 1;
                end
`endif
            end
            if (psum_gbf_w_en_for_init && psum_gbf_w_en &&
                psum_gbf_w_addr_for_init == psum_gbf_w_addr) begin
                wdrop = 1; exp_col = 1;
            end
            if (psum_gbf_w_en && !wdrop) begin
                if (psum_gbf_w_num) model[psum_gbf_w_addr][511:256] = psum_gbf_w_data;
                else                model[psum_gbf_w_addr][255:0]   = psum_gbf_w_data;
            end
            if (psum_gbf_w_en_for_init) model[psum_gbf_w_addr_for_init] = '0;
            exp_rv = psum_gbf_r_en;
            if (psum_gbf_r_en) exp_rdata = model[psum_gbf_r_addr];
        end
        @(posedge clk);
        @(negedge clk);
        check("r_valid", 512'(psum_gbf_r_valid), 512'(exp_rv));
        check("r_data", psum_gbf_r_data, exp_rdata);
        check("collision", 512'(collision), 512'(exp_col));
        check("drain_done", 512'(drain_done), 512'(done_exp));
        check("drain_busy", 512'(drain_busy), 512'(dq.size() != 0));
        if (dq.size() == 0) check("drain_valid_idle", 512'(drain_valid), 512'(0));
        if (chk_stall) check("fetch_stall", 512'(drain_valid), 512'(0));
        if (chk_fetch) check("fetch_latency", 512'(drain_valid), 512'(1));
    endtask

    task automatic rand_cycle(input bit allow_wr, input bit allow_coll);
        idle_inputs();
        psum_gbf_w_en   = allow_wr && ($urandom_range(0, 1) == 1);
        psum_gbf_w_addr = 5'($urandom);
        psum_gbf_w_num  = 1'($urandom);
        psum_gbf_w_data = rnd256();
        psum_gbf_w_en_for_init   = allow_wr && ($urandom_range(0, 4) == 0);
        psum_gbf_w_addr_for_init = 5'($urandom);
        if (!allow_coll && psum_gbf_w_addr_for_init == psum_gbf_w_addr)
            psum_gbf_w_addr_for_init = psum_gbf_w_addr + 5'd1;
        psum_gbf_r_en   = ($urandom_range(0, 2) == 0);
        psum_gbf_r_addr = 5'($urandom);
        drain_ready     = ($urandom_range(0, 3) != 0);
        tick();
    endtask

    // Run one drain to completion; mode 1 toggles ready, stall_hold forces r_en early on
    task automatic run_drain(input int base, input int len, input bit toggle, input bit stall_hold);
        int it;
        it = 0;
        idle_inputs();
        drain_start = 1'b1;
        drain_base  = 5'(base);
        drain_len   = 6'(len);
        tick();
        while (dq.size() != 0 && it < 400) begin
            idle_inputs();
            psum_gbf_r_en   = ($urandom_range(0, 3) == 0);
            psum_gbf_r_addr = 5'($urandom);
            if (stall_hold && it < 3) psum_gbf_r_en = 1'b1;
            drain_ready = toggle ? (it % 2 == 1) : ($urandom_range(0, 3) != 0);
            if (it == 3) begin
                drain_start = 1'b1;
                drain_base  = 5'($urandom);
                drain_len   = 6'($urandom_range(1, 32));
            end
            tick();
            it++;
        end
        if (dq.size() != 0) check("drain_timeout", 512'(1), 512'(0));
        idle_inputs();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_col = 0; exp_rv = 0; exp_rdata = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("rst_drain_data", drain_data, 512'(0));
        check("rst_drain_addr", 512'(drain_addr), 512'(0));
        reset = 1'b1;

        // Fill every row so reads compare against defined contents
        for (int r = 0; r < 32; r++) begin
            for (int h = 0; h < 2; h++) begin
                idle_inputs();
                psum_gbf_w_en   = 1'b1;
                psum_gbf_w_addr = 5'(r);
                psum_gbf_w_num  = 1'(h);
                psum_gbf_w_data = rnd256();
                tick();
            end
        end

        // Half-row writes then a full-row read
        idle_inputs();
        psum_gbf_w_en = 1'b1; psum_gbf_w_addr = 5'd3; psum_gbf_w_num = 1'b0;
        psum_gbf_w_data = {32{8'hAA}};
        tick();
        psum_gbf_w_num = 1'b1; psum_gbf_w_data = {32{8'h55}};
        tick();
        idle_inputs();
        psum_gbf_r_en = 1'b1; psum_gbf_r_addr = 5'd3;
        tick();
        check("t1_rdata", psum_gbf_r_data, {{32{8'h55}}, {32{8'hAA}}});
        check("t1_rvalid", 512'(psum_gbf_r_valid), 512'(1));

        // Read during write to the same row returns the new half
        idle_inputs();
        psum_gbf_w_en = 1'b1; psum_gbf_w_addr = 5'd5; psum_gbf_w_num = 1'b1;
        psum_gbf_w_data = {8{32'hC0FFEE01}};
        psum_gbf_r_en = 1'b1; psum_gbf_r_addr = 5'd5;
        tick();
        check("t3_bypass", 512'(psum_gbf_r_data[511:256]), 512'({8{32'hC0FFEE01}}));

        // Random traffic without same-row init/write conflicts
        for (int i = 0; i < 300; i++) rand_cycle(1'b1, 1'b0);
        check("no_collision_yet", 512'(collision), 512'(0));

        // Init and write to the same row: init wins, collision sticks
        idle_inputs();
        psum_gbf_w_en = 1'b1; psum_gbf_w_addr = 5'd7; psum_gbf_w_num = 1'b0;
        psum_gbf_w_data = {32{8'h11}};
        psum_gbf_w_en_for_init = 1'b1; psum_gbf_w_addr_for_init = 5'd7;
        tick();
        idle_inputs();
        psum_gbf_r_en = 1'b1; psum_gbf_r_addr = 5'd7;
        tick();
        check("t2_row7_zero", psum_gbf_r_data, 512'(0));
        check("t2_collision", 512'(collision), 512'(1));

        // Wrap-around drain with ready toggling
        for (int r = 0; r < 4; r++) begin
            idle_inputs();
            psum_gbf_w_en   = 1'b1;
            psum_gbf_w_addr = 5'((30 + r) % 32);
            psum_gbf_w_data = 256'((30 + r) % 32);
            tick();
            psum_gbf_w_num  = 1'b1;
            psum_gbf_w_data = '0;
            tick();
        end
        run_drain(30, 4, 1'b1, 1'b0);
        check("t4_busy_after", 512'(drain_busy), 512'(0));

        // Drain with external reads holding the port for three cycles
        run_drain(5, 3, 1'b0, 1'b1);

        // Assorted random drains, including len 0 meaning the full depth
        run_drain(int'($urandom_range(0, 31)), 0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 20; i++) rand_cycle(1'b1, 1'b1);
            run_drain(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)), 1'b0, 1'b0);
        end

        // Reset in the middle of a drain
        idle_inputs();
        drain_start = 1'b1; drain_base = 5'd10; drain_len = 6'd8;
        tick();
        for (int i = 0; i < 40 && dq.size() > 6; i++) begin
            idle_inputs();
            drain_ready = 1'b1;
            tick();
        end
        idle_inputs();
        drain_ready = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_valid", 512'(drain_valid), 512'(0));
        check("t6_busy", 512'(drain_busy), 512'(0));
        check("t6_collision", 512'(collision), 512'(0));
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            tick();
        end
        for (int r = 0; r < 32; r++) begin
            idle_inputs();
            psum_gbf_r_en = 1'b1; psum_gbf_r_addr = 5'(r);
            tick();
        end

        // Final random traffic with conflicts allowed
        for (int i = 0; i < 200; i++) rand_cycle(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
